// File: rtl/sump_cmd_rx.sv
// SUMP command receiver: classifies UART bytes into short and long commands and assembles long-command payloads.
// Optional payload inactivity timeout enabled by defining CMD_TIMEOUT_EN.
module sump_cmd_rx #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned PLD_BYTES   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  stb_i,
  input  logic [7:0]                                            byte_i,
  output logic                                                  busy_o,
  output logic                                                  sft_rst_o,
  output logic                                                  arm_o,
  output logic                                                  id_o,
  output logic                                                  rd_meta_o,
  output logic                                                  fin_now_o,
  output logic                                                  rd_inp_o,
  output logic                                                  xon_o,
  output logic                                                  xoff_o,
  output logic                                                  set_mask_o,
  output logic                                                  set_val_o,
  output logic                                                  set_cfg_o,
  output logic                                                  set_div_o,
  output logic                                                  set_cnt_o,
  output logic                                                  set_flgs_o,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] stg_o,
  output logic [8*PLD_BYTES-1:0]                                pld_o,
  output logic                                                  err_o,
  output logic                                                  abort_o
);

  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned CW = (PLD_BYTES > 1) ? $clog2(PLD_BYTES) : 1;
  localparam int unsigned PW = 8 * PLD_BYTES;

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t          state_q;
  logic [6:0]      opc_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   buf_q;
  logic [7:0]      short_q;
  logic [5:0]      long_q;

  logic [7:0]      short_c;
  logic [5:0]      long_c;
  logic [SW-1:0]   stg_c;
  logic [PW-1:0]   asm_c;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0]   tmo_q;
`else
  logic            unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // Short opcode decode straight from the incoming byte
  always_comb begin
    short_c = '0;
    case (byte_i[6:0])
      7'h00:   short_c[0] = 1'b1;
      7'h01:   short_c[1] = 1'b1;
      7'h02:   short_c[2] = 1'b1;
      7'h04:   short_c[3] = 1'b1;
      7'h05:   short_c[4] = 1'b1;
      7'h06:   short_c[5] = 1'b1;
      7'h11:   short_c[6] = 1'b1;
      7'h13:   short_c[7] = 1'b1;
      default: short_c = '0;
    endcase
  end

  // Long opcode decode from the latched opcode; an empty result means error
  always_comb begin
    long_c = '0;
    stg_c  = SW'(opc_q[3:2]);
    if (opc_q[6:4] == 3'b100) begin
      if (opc_q[1:0] != 2'b11 && 32'(opc_q[3:2]) < NUM_STAGES)
        long_c[3'(opc_q[1:0])] = 1'b1;
    end else if (opc_q[6:2] == 5'b00000 && opc_q[1:0] != 2'b11) begin
      long_c[3'd3 + 3'(opc_q[1:0])] = 1'b1;
    end
  end

  // Payload buffer with the current byte dropped into its slot
  always_comb begin
    asm_c = buf_q;
    asm_c[{cnt_q, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      opc_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      short_q <= '0;
      long_q  <= '0;
      busy_o  <= 1'b0;
      stg_o   <= '0;
      pld_o   <= '0;
      err_o   <= 1'b0;
      abort_o <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      short_q <= '0;
      long_q  <= '0;
      err_o   <= 1'b0;
      abort_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stb_i) begin
            if (!byte_i[7]) begin
              short_q <= short_c;
              err_o   <= ~|short_c;
            end else begin
              opc_q   <= byte_i[6:0];
              cnt_q   <= '0;
              buf_q   <= '0;
              busy_o  <= 1'b1;
              state_q <= PAYLOAD;
`ifdef CMD_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (stb_i) begin
            buf_q <= asm_c;
`ifdef CMD_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (cnt_q == CW'(PLD_BYTES - 1)) begin
              cnt_q   <= '0;
              busy_o  <= 1'b0;
              state_q <= IDLE;
              if (|long_c) begin
                long_q <= long_c;
                pld_o  <= asm_c;
                if (|long_c[2:0]) stg_o <= stg_c;
              end else begin
                err_o <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef CMD_TIMEOUT_EN
          // Expiry only when no byte arrives on the same cycle
          else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            busy_o  <= 1'b0;
            abort_o <= 1'b1;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {xoff_o, xon_o, rd_inp_o, fin_now_o, rd_meta_o, id_o, arm_o, sft_rst_o} = short_q;
  assign {set_flgs_o, set_cnt_o, set_div_o, set_cfg_o, set_val_o, set_mask_o}   = long_q;

endmodule

// File: tb/tb_sump_cmd_rx.sv
// Directed bench for sump_cmd_rx with a byte-list reference model checked every cycle.
module tb_sump_cmd_rx;
  localparam int NS = 2;
  localparam int PB = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_i, stb_i;
  logic [7:0]  byte_i;
  logic        busy_o, err_o, abort_o;
  logic        sft_rst_o, arm_o, id_o, rd_meta_o, fin_now_o, rd_inp_o, xon_o, xoff_o;
  logic        set_mask_o, set_val_o, set_cfg_o, set_div_o, set_cnt_o, set_flgs_o;
  logic [0:0]  stg_o;
  logic [31:0] pld_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  sump_cmd_rx #(.NUM_STAGES(NS), .PLD_BYTES(PB), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .stb_i(stb_i), .byte_i(byte_i), .busy_o(busy_o),
    .sft_rst_o(sft_rst_o), .arm_o(arm_o), .id_o(id_o), .rd_meta_o(rd_meta_o),
    .fin_now_o(fin_now_o), .rd_inp_o(rd_inp_o), .xon_o(xon_o), .xoff_o(xoff_o),
    .set_mask_o(set_mask_o), .set_val_o(set_val_o), .set_cfg_o(set_cfg_o),
    .set_div_o(set_div_o), .set_cnt_o(set_cnt_o), .set_flgs_o(set_flgs_o),
    .stg_o(stg_o), .pld_o(pld_o), .err_o(err_o), .abort_o(abort_o)
  );

  // bit 0 sft_rst .. bit 7 xoff, bit 8 set_mask .. bit 13 set_flgs
  logic [13:0] strb;
  assign strb = {set_flgs_o, set_cnt_o, set_div_o, set_cfg_o, set_val_o, set_mask_o,
                 xoff_o, xon_o, rd_inp_o, fin_now_o, rd_meta_o, id_o, arm_o, sft_rst_o};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: collect bytes after a long opcode, judge the command when PB bytes are in
  logic [13:0] m_strb;
  logic        m_err, m_abort, m_busy, m_ok;
  logic [0:0]  m_stg;
  logic [31:0] m_pld;
  bit          m_in, m_valid;
  int          m_opc, m_idle;
  int          m_bytes[$];

  function automatic void m_complete();
    int o = m_opc;
    bit ok = 0;
    logic [31:0] p = 0;
    for (int i = 0; i < m_bytes.size(); i++) p = p | (32'(m_bytes[i]) << (8 * i));
    if (o >= 'hC0 && o <= 'hCF) begin
      int s = (o - 'hC0) / 4;
      int k = (o - 'hC0) % 4;
      if (k < 3 && s < NS) begin
        ok = 1;
        m_strb[8 + k] = 1'b1;
        m_stg = 1'(s);
      end
    end else if (o >= 'h80 && o <= 'h82) begin
      ok = 1;
      m_strb[11 + o - 'h80] = 1'b1;
    end
    if (ok) m_pld = p;
    else m_err = 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_strb = '0; m_err = 1'b0; m_abort = 1'b0;
    if (rst_i) begin
      m_in = 0; m_pld = '0; m_stg = '0; m_idle = 0; m_bytes.delete(); m_valid = 1;
    end else if (!m_in) begin
      if (stb_i) begin
        if (!byte_i[7]) begin
          case (int'(byte_i))
            'h00: m_strb[0] = 1'b1;
            'h01: m_strb[1] = 1'b1;
            'h02: m_strb[2] = 1'b1;
            'h04: m_strb[3] = 1'b1;
            'h05: m_strb[4] = 1'b1;
            'h06: m_strb[5] = 1'b1;
            'h11: m_strb[6] = 1'b1;
            'h13: m_strb[7] = 1'b1;
            default: m_err = 1'b1;
          endcase
        end else begin
          m_in = 1; m_opc = int'(byte_i); m_idle = 0; m_bytes.delete();
        end
      end
    end else if (stb_i) begin
      m_bytes.push_back(int'(byte_i));
      m_idle = 0;
      if (m_bytes.size() == PB) begin
        m_in = 0;
        m_complete();
      end
    end else begin
`ifdef CMD_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_in = 0;
        m_abort = 1'b1;
      end
`endif
    end
    m_busy = m_in;
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("strobes", 64'(strb), 64'(m_strb));
      chk("err", 64'(err_o), 64'(m_err));
      chk("abort", 64'(abort_o), 64'(m_abort));
      chk("busy", 64'(busy_o), 64'(m_busy));
      chk("stg", 64'(stg_o), 64'(m_stg));
      chk("pld", 64'(pld_o), 64'(m_pld));
      chk("exclusive", 64'($countones({strb, err_o}) <= 1), 64'(1));
    end
  end

  // Drives for one cycle; consecutive calls give back-to-back bytes
  task automatic send(input logic [7:0] b);
    stb_i = 1'b1; byte_i = b;
    @(posedge clk); #1;
    stb_i = 1'b0; byte_i = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] shorts[8];
    logic [7:0] longs[6];
    int first_abort;
    shorts = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h11, 8'h13};
    longs  = '{8'h80, 8'h82, 8'hC1, 8'hC2, 8'hC3, 8'hC8};
    rst_i = 1'b1; stb_i = 1'b0; byte_i = 8'h00;
    idle(3);
    rst_i = 1'b0;
    chk("reset_busy", 64'(busy_o), 0);
    chk("reset_pld", 64'(pld_o), 0);
    chk("reset_strb", 64'(strb), 0);

    send(8'h01);
    chk("arm_pulse", 64'(strb), 64'h2);
    idle(1);
    chk("arm_single", 64'(arm_o), 0);

    send(8'hC4);
    chk("mask_busy0", 64'(busy_o), 1);
    send(8'h78); send(8'h56); send(8'h34);
    chk("mask_busy3", 64'(busy_o), 1);
    send(8'h12);
    chk("mask_strb", 64'(strb), 64'h100);
    chk("mask_busy_drop", 64'(busy_o), 0);
    chk("mask_stg", 64'(stg_o), 1);
    chk("mask_pld", 64'(pld_o), 64'h12345678);
    idle(2);

    send(8'hCC); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("bad_stage_err", 64'(err_o), 1);
    chk("bad_stage_pld", 64'(pld_o), 64'h12345678);
    chk("bad_stage_stg", 64'(stg_o), 1);
    send(8'h03);
    chk("bad_short_err", 64'(err_o), 1);
    idle(1);

    send(8'h81); send(8'h00); send(8'h00); send(8'h00);
    chk("zero_payload_no_sft", 64'(sft_rst_o), 0);
    send(8'h00);
    chk("cnt_strb", 64'(strb), 64'h1000);
    chk("cnt_pld", 64'(pld_o), 0);

    send(8'h82); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("flgs_strb", 64'(strb), 64'h2000);
    send(8'h13);
    chk("b2b_xoff", 64'(strb), 64'h80);
    chk("flgs_pld", 64'(pld_o), 64'h44332211);

    foreach (shorts[i]) begin send(shorts[i]); idle(1); end
    send(8'h7F); idle(1);
    foreach (longs[i]) begin
      send(longs[i]);
      for (int j = 0; j < PB; j++) send(8'(8'h10 * i + j));
      idle(1);
    end

    send(8'hC0); send(8'h01); send(8'h02);
    rst_i = 1'b1; idle(1); rst_i = 1'b0;
    send(8'h02);
    chk("post_rst_id", 64'(strb), 64'h4);
    chk("post_rst_busy", 64'(busy_o), 0);
    idle(3);

    send(8'hC1); send(8'h55);
    first_abort = 0;
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      if (abort_o && first_abort == 0) first_abort = k;
    end
`ifdef CMD_TIMEOUT_EN
    chk("abort_cycle", 64'(first_abort), 16);
    chk("abort_busy", 64'(busy_o), 0);
    send(8'h01);
    chk("after_abort_arm", 64'(arm_o), 1);
`else
    chk("no_abort", 64'(first_abort), 0);
    chk("waits_busy", 64'(busy_o), 1);
    rst_i = 1'b1; idle(1); rst_i = 1'b0;
`endif
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
